pow2_serial_checker: RTL
========================

Name: pow2_serial_checker

Overview:
- Upstream serial front-end for the power-of-two detector.
- Deserialises a bit stream into a W-bit word and flags whether the word has exactly one bit set (is a power of two).
- Reports the exponent of that bit and counts the accepted power-of-two words.
- Input side uses a valid/ready handshake. Output side holds the result until the consumer accepts it.

Parameters:
- W, 8, word width in bits (W >= 2).
- IW, $clog2(W), width of the exponent output (derived, not overridden).
- CW, 16, width of the power-of-two counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_bit is valid this cycle
- in_bit  input  1  serial data; the first bit accepted lands in out_word[0] (MSB)
- in_ready  output  1  block accepts a bit this cycle
- abort  input  1  synchronous discard of the word in progress or held
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_word  output  [0:W-1]  assembled word, x[0] = MSB
- out_pow2  output  1  exactly one bit of out_word is set
- out_exp  output  IW  exponent when out_pow2=1 (value = 2^out_exp, i.e. W-1-i for set bit x[i]); 0 otherwise
- pow2_count  output  CW  number of accepted words with out_pow2=1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=COLLECT; bit counter=0; ones-tracker=NONE.
  - in_ready=1, out_valid=0, out_word=0, out_pow2=0, out_exp=0, pow2_count=0.
- Input transfer: a bit is accepted when in_valid & in_ready on a rising edge.
- COLLECT state (in_ready=1):
  - Each accepted bit shifts into the next position: bit k goes to out_word[k].
  - The bit counter increments on each accepted bit.
  - Ones-tracker: NONE --1--> ONE (record exponent W-1-k); ONE --1--> MANY; MANY stays MANY; 0-bits leave the tracker unchanged.
  - When bit W-1 is accepted, go to HOLD on the same edge, with these values registered:
    - out_word = assembled word
    - out_pow2 = (tracker ends at ONE)
    - out_exp = recorded exponent if out_pow2, else 0
  - out_valid=1 in the cycle after the last bit is accepted (latency 1).
- HOLD state (in_ready=0, out_valid=1):
  - out_word/out_pow2/out_exp stay stable until accepted.
  - On out_valid & out_ready: pow2_count += out_pow2 (saturates at 2^CW-1, no wrap); go to COLLECT with counter and tracker cleared; out_valid=0 next cycle.
  - One idle cycle between words is required: no bit is accepted in the handshake cycle.
- Outputs in COLLECT: out_word/out_pow2/out_exp hold the last delivered values (0 after reset).
  - out_valid=0, so consumers must ignore them.
- abort (synchronous, highest priority):
  - Next state is COLLECT with bit counter=0, tracker=NONE, out_valid=0.
  - abort together with in_valid: the bit is discarded.
  - abort in HOLD without out_ready: the result is dropped and pow2_count is unchanged.
  - abort in HOLD with out_ready: the handshake still completes (pow2_count updates), then the state is COLLECT.
- All-zero word: tracker stays NONE -> out_pow2=0, out_exp=0.
- Reset mid-word or mid-HOLD: everything returns to reset values immediately, including pow2_count.

Test Plan:
- Reset, then send bits 0,0,0,1,0,0,0,0 with in_valid held high. Required response:
  - out_valid=1 exactly one cycle after the 8th bit
  - out_word=8'b00010000, out_pow2=1, out_exp=4, in_ready=0
  - after out_ready pulse: pow2_count=1
- Send 1,0,0,0,0,1,0,0 -> out_word=8'b10000100, out_pow2=0, out_exp=0; pow2_count unchanged after acceptance.
- Send 8 zeros -> out_pow2=0, out_exp=0. Send 0,0,0,0,0,0,0,1 -> out_pow2=1, out_exp=0. Send 1 then 7 zeros -> out_exp=7.
- Hold out_ready=0 for 5 cycles in HOLD while in_valid toggles. Required response:
  - outputs stable, in_ready=0, no bits consumed
  - on out_ready=1, next word starts after exactly one idle cycle
- Pulse abort after 3 bits (1,1,0), then send 0,1,0,0,0,0,0,0 -> out_word=8'b01000000, out_pow2=1, out_exp=6. Abort in HOLD with out_ready=0 -> out_valid=0, pow2_count unchanged.
- Preload by streaming 65535 power-of-two words (or force pow2_count=16'hFFFF), then accept another one -> pow2_count stays 16'hFFFF. Assert rst_n=0 mid-word -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pow2_serial_checker_if.sv
// Handshake bundle for the serial power-of-two checker: the bit-stream input
// side, and the result output side that is held until the consumer takes it.
interface pow2_serial_checker_if #(
  parameter int W  = 8,
  parameter int CW = 16
);
  localparam int IW = $clog2(W);

  logic           in_valid;
  logic           in_bit;
  logic           in_ready;
  logic           abort;
  logic           out_valid;
  logic           out_ready;
  logic [0:W-1]   out_word;
  logic           out_pow2;
  logic [IW-1:0]  out_exp;
  logic [CW-1:0]  pow2_count;

  modport master (
    output in_valid, in_bit, abort, out_ready,
    input  in_ready, out_valid, out_word, out_pow2, out_exp, pow2_count
  );

  modport slave (
    input  in_valid, in_bit, abort, out_ready,
    output in_ready, out_valid, out_word, out_pow2, out_exp, pow2_count
  );
endinterface

// File: rtl/pow2_serial_checker.sv
// Deserialises W bits (first bit = MSB) into a word, flags words with exactly
// one bit set, reports that bit's exponent and counts accepted power-of-two words.
module pow2_serial_checker #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  pow2_serial_checker_if.slave  bus
);
  localparam int IW = $clog2(W);

  typedef enum logic [0:0] {COLLECT, HOLD} state_e;
  typedef enum logic [1:0] {NONE, ONE, MANY} trk_e;

  state_e         state_q, state_d;
  trk_e           trk_q, trk_d;
  logic [IW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  exp_q, exp_d;
  logic [0:W-1]   sh_q, sh_d;
  logic [0:W-1]   out_word_q, out_word_d;
  logic           out_pow2_q, out_pow2_d;
  logic [IW-1:0]  out_exp_q, out_exp_d;
  logic [CW-1:0]  count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      trk_q      <= NONE;
      cnt_q      <= '0;
      exp_q      <= '0;
      sh_q       <= '0;
      out_word_q <= '0;
      out_pow2_q <= 1'b0;
      out_exp_q  <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      trk_q      <= trk_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      sh_q       <= sh_d;
      out_word_q <= out_word_d;
      out_pow2_q <= out_pow2_d;
      out_exp_q  <= out_exp_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    trk_d      = trk_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    sh_d       = sh_q;
    out_word_d = out_word_q;
    out_pow2_d = out_pow2_q;
    out_exp_d  = out_exp_q;
    count_d    = count_q;

    case (state_q)
      COLLECT: begin
        if (bus.in_valid && !bus.abort) begin
          sh_d[cnt_q] = bus.in_bit;
          cnt_d       = cnt_q + IW'(1);
          if (bus.in_bit) begin
            case (trk_q)
              NONE: begin
                trk_d = ONE;
                exp_d = IW'(W - 1) - cnt_q;
              end
              default: trk_d = MANY;
            endcase
          end
          // Last bit: publish the word on this same edge and start afresh.
          if (cnt_q == IW'(W - 1)) begin
            state_d    = HOLD;
            out_word_d = sh_d;
            out_pow2_d = (trk_d == ONE);
            out_exp_d  = (trk_d == ONE) ? exp_d : '0;
            cnt_d      = '0;
            trk_d      = NONE;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (out_pow2_q && (count_q != {CW{1'b1}}))
            count_d = count_q + CW'(1);
          state_d = COLLECT;
          cnt_d   = '0;
          trk_d   = NONE;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Abort overrides everything except a handshake completing in this cycle.
    if (bus.abort) begin
      state_d = COLLECT;
      cnt_d   = '0;
      trk_d   = NONE;
    end
  end

  assign bus.in_ready   = (state_q == COLLECT);
  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_word   = out_word_q;
  assign bus.out_pow2   = out_pow2_q;
  assign bus.out_exp    = out_exp_q;
  assign bus.pow2_count = count_q;
endmodule
